// File: rtl/risc_v_multicycle_controller.sv
// rtl/risc_v_multicycle_controller.sv - multicycle RV32I control FSM for a shared-memory datapath
module risc_v_multicycle_controller #(
  parameter logic RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       equal,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       old_pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] immediate_control,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JAL_LINK, S_LUI, S_AUIPC
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000, ALU_SLTU = 4'b1001, ALU_PASS_B = 4'b1010;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b100;

  state_t state;
  logic   branch_taken;
  logic   branch_bad_funct3;
  logic   decode_illegal;

  // Opcode dispatch out of DECODE; unsupported opcodes fall back to FETCH.
  function automatic state_t decode_target(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0100011: decode_target = S_MEMADR;
      7'b0110011:             decode_target = S_EXEC_R;
      7'b0010011:             decode_target = S_EXEC_I;
      7'b1100011:             decode_target = S_BRANCH;
      7'b1101111:             decode_target = S_JAL;
      7'b1100111:             decode_target = S_JALR;
      7'b0110111:             decode_target = S_LUI;
      7'b0010111:             decode_target = S_AUIPC;
      default:                decode_target = S_FETCH;
    endcase
  endfunction

  // ALU operation for register/immediate arithmetic; SUB exists only in R-type.
  function automatic logic [3:0] exec_alu_op(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  exec_alu_op = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu_op = ALU_SLL;
      3'b010:  exec_alu_op = ALU_SLT;
      3'b011:  exec_alu_op = ALU_SLTU;
      3'b100:  exec_alu_op = ALU_XOR;
      3'b101:  exec_alu_op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  exec_alu_op = ALU_OR;
      default: exec_alu_op = ALU_AND;
    endcase
  endfunction

  // Branch condition evaluation from the comparator flags.
  always_comb begin
    branch_taken      = 1'b0;
    branch_bad_funct3 = (funct3 == 3'b010) || (funct3 == 3'b011);
    decode_illegal    = (decode_target(opcode) == S_FETCH);
    case (funct3)
      3'b000:  branch_taken = equal;
      3'b001:  branch_taken = !equal;
      3'b100:  branch_taken = less_than;
      3'b101:  branch_taken = !less_than;
      3'b110:  branch_taken = less_than_unsigned;
      3'b111:  branch_taken = !less_than_unsigned;
      default: branch_taken = 1'b0;
    endcase
  end

  // State register and sequencing; memory states hold until mem_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state <= S_FETCH;
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_target(opcode);
        S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_ALUWB;
        S_EXEC_I:   state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_JAL_LINK;
        S_JAL_LINK: state <= S_FETCH;
        S_LUI:      state <= S_ALUWB;
        S_AUIPC:    state <= S_ALUWB;
      endcase
    end
  end

  // Per-state datapath controls; everything is forced low while reset is held.
  always_comb begin
    pc_write          = 1'b0;
    old_pc_write      = 1'b0;
    ir_write          = 1'b0;
    adr_src           = 1'b0;
    mem_req           = 1'b0;
    mem_write         = 1'b0;
    alu_src_a         = 2'b00;
    alu_src_b         = 2'b00;
    alu_control       = ALU_ADD;
    immediate_control = IMM_I;
    result_src        = 2'b00;
    reg_write         = 1'b0;
    instr_retired     = 1'b0;
    illegal_instr     = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          mem_req      = 1'b1;
          alu_src_b    = 2'b10;
          result_src   = 2'b10;
          ir_write     = mem_ready;
          old_pc_write = mem_ready;
          pc_write     = mem_ready;
        end
        S_DECODE: begin
          alu_src_a         = 2'b01;
          alu_src_b         = 2'b01;
          immediate_control = IMM_B;
          illegal_instr     = decode_illegal;
        end
        S_MEMADR: begin
          alu_src_a         = 2'b10;
          alu_src_b         = 2'b01;
          immediate_control = opcode[5] ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src    = 2'b01;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req       = 1'b1;
          mem_write     = 1'b1;
          adr_src       = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_control = exec_alu_op(funct3, funct7_5, 1'b1);
        end
        S_EXEC_I: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = exec_alu_op(funct3, funct7_5, 1'b0);
        end
        S_ALUWB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b10;
          alu_control   = ALU_SUB;
          instr_retired = 1'b1;
          pc_write      = branch_taken && !branch_bad_funct3;
          illegal_instr = branch_bad_funct3;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          pc_write   = 1'b1;
          result_src = 2'b10;
        end
        S_JAL_LINK: begin
          alu_src_a     = 2'b01;
          alu_src_b     = 2'b10;
          result_src    = 2'b10;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_LUI: begin
          alu_src_b         = 2'b01;
          immediate_control = IMM_U;
          alu_control       = ALU_PASS_B;
        end
        S_AUIPC: begin
          alu_src_a         = 2'b01;
          alu_src_b         = 2'b01;
          immediate_control = IMM_U;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// tb/tb_risc_v_multicycle_controller.sv - directed bench for the multicycle control FSM
module tb_risc_v_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, start, funct7_5, equal, less_than, less_than_unsigned, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic       pc_write, old_pc_write, ir_write, adr_src, mem_req, mem_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] immediate_control;
  logic       reg_write, instr_retired, illegal_instr;

  logic       d2_pc_write, d2_old_pc_write, d2_ir_write, d2_adr_src, d2_mem_req, d2_mem_write;
  logic [1:0] d2_alu_src_a, d2_alu_src_b, d2_result_src;
  logic [3:0] d2_alu_control;
  logic [2:0] d2_immediate_control;
  logic       d2_reg_write, d2_instr_retired, d2_illegal_instr;

  int checks = 0;
  int passes = 0;

  logic [21:0] v_fetch, v_fetch_wait, v_decode, v_aluwb;

  wire [21:0] ctl = {pc_write, old_pc_write, ir_write, adr_src, mem_req, mem_write, alu_src_a,
                     alu_src_b, alu_control, immediate_control, result_src, reg_write,
                     instr_retired, illegal_instr};
  wire [21:0] d2ctl = {d2_pc_write, d2_old_pc_write, d2_ir_write, d2_adr_src, d2_mem_req,
                       d2_mem_write, d2_alu_src_a, d2_alu_src_b, d2_alu_control,
                       d2_immediate_control, d2_result_src, d2_reg_write, d2_instr_retired,
                       d2_illegal_instr};

  risc_v_multicycle_controller dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .equal(equal), .less_than(less_than),
    .less_than_unsigned(less_than_unsigned), .mem_ready(mem_ready),
    .pc_write(pc_write), .old_pc_write(old_pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .immediate_control(immediate_control), .result_src(result_src),
    .reg_write(reg_write), .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  risc_v_multicycle_controller #(.RESET_STATE_FETCH(1'b0)) dut_idle (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .equal(equal), .less_than(less_than),
    .less_than_unsigned(less_than_unsigned), .mem_ready(mem_ready),
    .pc_write(d2_pc_write), .old_pc_write(d2_old_pc_write), .ir_write(d2_ir_write),
    .adr_src(d2_adr_src), .mem_req(d2_mem_req), .mem_write(d2_mem_write),
    .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b), .alu_control(d2_alu_control),
    .immediate_control(d2_immediate_control), .result_src(d2_result_src),
    .reg_write(d2_reg_write), .instr_retired(d2_instr_retired), .illegal_instr(d2_illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] mk(input logic pcw, input logic opcw, input logic irw,
                                     input logic adr, input logic req, input logic wr,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [3:0] alu, input logic [2:0] imm,
                                     input logic [1:0] rs, input logic rw, input logic ret,
                                     input logic ill);
    return {pcw, opcw, irw, adr, req, wr, sa, sb, alu, imm, rs, rw, ret, ill};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== 22'd0) $display("FAIL reset_outputs: got %h expected %h", ctl, 22'd0);
    else passes++;
    checks++;
    if (d2ctl !== 22'd0) $display("FAIL reset_outputs_idle: got %h expected %h", d2ctl, 22'd0);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_r_type();
    logic [21:0] e [4];
    e[0] = v_fetch;
    e[1] = v_decode;
    e[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,4'b0001,3'd0,2'd0,1'b0,1'b0,1'b0);
    e[3] = v_aluwb;
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== e[i]) $display("FAIL r_type_sub cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_exec_i();
    logic [21:0] e [4];
    logic [2:0]  f3 [2];
    logic [3:0]  op [2];
    f3[0] = 3'b000; op[0] = 4'b0000;
    f3[1] = 3'b101; op[1] = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      e[0] = v_fetch;
      e[1] = v_decode;
      e[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,op[k],3'd0,2'd0,1'b0,1'b0,1'b0);
      e[3] = v_aluwb;
      opcode = 7'b0010011; funct3 = f3[k]; funct7_5 = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (ctl !== e[i]) $display("FAIL exec_i%0d cyc%0d: got %h expected %h", k, i, ctl, e[i]);
        else passes++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_load();
    logic [21:0] e [8];
    logic        r [8];
    e[0] = v_fetch;  r[0] = 1'b1;
    e[1] = v_decode; r[1] = 1'b1;
    e[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,4'd0,3'd0,2'd0,1'b0,1'b0,1'b0); r[2] = 1'b1;
    for (int i = 3; i < 7; i++) begin
      e[i] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,4'd0,3'd0,2'd0,1'b0,1'b0,1'b0);
      r[i] = (i == 6);
    end
    e[7] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,4'd0,3'd0,2'd1,1'b1,1'b1,1'b0); r[7] = 1'b1;
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (ctl !== e[i]) $display("FAIL load_wait cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3 [3];
    logic       eq [3];
    logic       pcw [3];
    logic       ill [3];
    logic [21:0] e [3];
    f3[0] = 3'b000; eq[0] = 1'b1; pcw[0] = 1'b1; ill[0] = 1'b0;
    f3[1] = 3'b000; eq[1] = 1'b0; pcw[1] = 1'b0; ill[1] = 1'b0;
    f3[2] = 3'b010; eq[2] = 1'b1; pcw[2] = 1'b0; ill[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e[0] = v_fetch;
      e[1] = v_decode;
      e[2] = mk(pcw[k],1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,4'b0001,3'd0,2'd0,1'b0,1'b1,ill[k]);
      opcode = 7'b1100011; funct3 = f3[k]; equal = eq[k]; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (ctl !== e[i]) $display("FAIL branch%0d cyc%0d: got %h expected %h", k, i, ctl, e[i]);
        else passes++;
        @(negedge clk);
      end
    end
    equal = 1'b0;
  endtask

  task automatic test_illegal();
    logic [21:0] e [3];
    logic        r [3];
    e[0] = v_fetch; r[0] = 1'b1;
    e[1] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,4'd0,3'd2,2'd0,1'b0,1'b0,1'b1); r[1] = 1'b1;
    e[2] = v_fetch_wait; r[2] = 1'b0;
    opcode = 7'b1111111; funct3 = 3'b000; funct7_5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (ctl !== e[i]) $display("FAIL illegal_opcode cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_store_reset();
    logic [21:0] e [4];
    logic        r [4];
    e[0] = v_fetch;  r[0] = 1'b1;
    e[1] = v_decode; r[1] = 1'b1;
    e[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd1,4'd0,3'd1,2'd0,1'b0,1'b0,1'b0); r[2] = 1'b1;
    e[3] = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,2'd0,2'd0,4'd0,3'd0,2'd0,1'b0,1'b0,1'b0); r[3] = 1'b0;
    opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (ctl !== e[i]) $display("FAIL store cyc%0d: got %h expected %h", i, ctl, e[i]);
      else passes++;
      if (i < 3) @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_write} !== 2'b00)
      $display("FAIL store_reset_drop: got %b expected %b", {mem_req, mem_write}, 2'b00);
    else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== 22'd0) $display("FAIL store_reset_hold: got %h expected %h", ctl, 22'd0);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== v_fetch_wait) $display("FAIL store_reset_refetch: got %h expected %h", ctl, v_fetch_wait);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_idle_start();
    start = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (d2ctl !== 22'd0) $display("FAIL idle_hold cyc%0d: got %h expected %h", i, d2ctl, 22'd0);
      else passes++;
      @(negedge clk);
    end
    start = 1'b1;
    #1;
    checks++;
    if (d2ctl !== 22'd0) $display("FAIL idle_start_same_cycle: got %h expected %h", d2ctl, 22'd0);
    else passes++;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (d2ctl !== v_fetch_wait) $display("FAIL idle_to_fetch: got %h expected %h", d2ctl, v_fetch_wait);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    equal = 1'b0; less_than = 1'b0; less_than_unsigned = 1'b0; mem_ready = 1'b0;
    v_fetch      = mk(1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,2'd0,2'd2,4'd0,3'd0,2'd2,1'b0,1'b0,1'b0);
    v_fetch_wait = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,2'd2,4'd0,3'd0,2'd2,1'b0,1'b0,1'b0);
    v_decode     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd1,4'd0,3'd2,2'd0,1'b0,1'b0,1'b0);
    v_aluwb      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,4'd0,3'd0,2'd0,1'b1,1'b1,1'b0);
    @(negedge clk);
    test_reset();
    test_r_type();
    test_exec_i();
    test_load();
    test_branch();
    test_illegal();
    test_store_reset();
    test_idle_start();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
